// File: rtl/tiny16_pkg.sv
// rtl/tiny16_pkg.sv - shared ALU opcodes, legality bounds and sequencer state encoding
package tiny16_pkg;

    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_MUL = 4'b0101;
    localparam logic [3:0] OP_DIV = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0111;
    localparam logic [3:0] OP_OR  = 4'b1000;
    localparam logic [3:0] OP_XOR = 4'b1001;
    localparam logic [3:0] OP_SHL = 4'b1010;
    localparam logic [3:0] OP_SHR = 4'b1011;

    localparam logic [3:0] OP_FIRST = OP_ADD;
    localparam logic [3:0] OP_LAST  = OP_SHR;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } seq_state_t;

endpackage

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - four-state sequencer: regfile read, one ALU strobe, writeback
module alu_seq_ctrl
    import tiny16_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_opcode,
    input  logic              req_ar,
    input  logic [REG_AW-1:0] req_rd,
    input  logic [REG_AW-1:0] req_rs1,
    input  logic [REG_AW-1:0] req_rs2,
    input  logic              req_use_imm,
    input  logic [DATA_W-1:0] req_imm,
    output logic [REG_AW-1:0] rf_raddr1,
    output logic [REG_AW-1:0] rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [3:0]        alu_opcode,
    output logic              alu_ar,
    output logic [DATA_W-1:0] alu_src1,
    output logic [DATA_W-1:0] alu_src2,
    output logic              alu_out_en,
    input  logic [DATA_W-1:0] alu_result,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  op_count
);

    seq_state_t        state, next_state;
    logic [3:0]        op_q;
    logic              ar_q;
    logic [REG_AW-1:0] rd_q, rs1_q, rs2_q;
    logic              use_imm_q;
    logic [DATA_W-1:0] imm_q;
    logic              err_q;
    logic [DATA_W-1:0] result_q;

    logic [DATA_W-1:0] src2;
    logic              illegal_op;
    logic              div_zero;
    logic              trap;

    assign src2       = use_imm_q ? imm_q : rf_rdata2;
    assign illegal_op = (op_q < OP_FIRST) || (op_q > OP_LAST);
    assign div_zero   = (op_q == OP_DIV) && (src2 == '0);
    assign trap       = illegal_op || div_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            op_q      <= '0;
            ar_q      <= 1'b0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            use_imm_q <= 1'b0;
            imm_q     <= '0;
            err_q     <= 1'b0;
            result_q  <= '0;
            op_count  <= '0;
        end else begin
            state <= next_state;
            if (state == ST_IDLE && req_valid) begin
                op_q      <= req_opcode;
                ar_q      <= req_ar;
                rd_q      <= req_rd;
                rs1_q     <= req_rs1;
                rs2_q     <= req_rs2;
                use_imm_q <= req_use_imm;
                imm_q     <= req_imm;
            end
            if (state == ST_EXEC) begin
                err_q <= trap;
                if (!trap) begin
                    result_q <= alu_result;
                end
            end
            if (state == ST_WB) begin
                err_q <= 1'b0;
                if (!err_q) begin
                    op_count <= op_count + CNT_W'(1);
                end
            end
        end
    end

    // Strobes are masked by rst so a reset cycle never leaks a write, done or flag update.
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        rf_raddr1  = '0;
        rf_raddr2  = '0;
        rf_we      = 1'b0;
        rf_waddr   = '0;
        rf_wdata   = '0;
        alu_opcode = '0;
        alu_ar     = 1'b0;
        alu_src1   = '0;
        alu_src2   = '0;
        alu_out_en = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    next_state = ST_READ;
                end
            end
            ST_READ: begin
                rf_raddr1  = rs1_q;
                rf_raddr2  = rs2_q;
                next_state = ST_EXEC;
            end
            ST_EXEC: begin
                alu_opcode = op_q;
                alu_ar     = ar_q;
                alu_src1   = rf_rdata1;
                alu_src2   = src2;
                alu_out_en = !trap && !rst;
                next_state = ST_WB;
            end
            ST_WB: begin
                done       = !rst;
                err        = err_q && !rst;
                rf_we      = !err_q && !rst;
                rf_waddr   = rd_q;
                rf_wdata   = result_q;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - directed bench with regfile/ALU models around alu_seq_ctrl
module tb_alu_seq_ctrl;
    import tiny16_pkg::*;

    localparam int DATA_W = 16;
    localparam int REG_AW = 3;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready;
    logic [3:0]        req_opcode;
    logic              req_ar;
    logic [REG_AW-1:0] req_rd, req_rs1, req_rs2;
    logic              req_use_imm;
    logic [DATA_W-1:0] req_imm;
    logic [REG_AW-1:0] rf_raddr1, rf_raddr2, rf_waddr;
    logic [DATA_W-1:0] rf_rdata1, rf_rdata2, rf_wdata;
    logic              rf_we;
    logic [3:0]        alu_opcode;
    logic              alu_ar;
    logic [DATA_W-1:0] alu_src1, alu_src2, alu_result;
    logic              alu_out_en;
    logic              done, err;
    logic [CNT_W-1:0]  op_count;

    int total = 0;
    int bad   = 0;
    int n_alu_en = 0;
    int n_we     = 0;
    int n_done   = 0;

    logic [DATA_W-1:0] regs [8];
    logic [1:0]        flags;
    logic [DATA_W:0]   alu_wide;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_ar(req_ar),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_use_imm(req_use_imm), .req_imm(req_imm),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alu_opcode(alu_opcode), .alu_ar(alu_ar),
        .alu_src1(alu_src1), .alu_src2(alu_src2),
        .alu_out_en(alu_out_en), .alu_result(alu_result),
        .done(done), .err(err), .op_count(op_count)
    );

    // Synchronous-read register file; reset preloads the operand values used below.
    always @(posedge clk) begin
        rf_rdata1 <= regs[rf_raddr1];
        rf_rdata2 <= regs[rf_raddr2];
        if (rst) begin
            regs[0] <= 16'd0; regs[1] <= 16'd5; regs[2] <= 16'd7; regs[3] <= 16'd0;
            regs[4] <= 16'd3; regs[5] <= 16'd5; regs[6] <= 16'd0; regs[7] <= 16'd0;
        end else if (rf_we) begin
            regs[rf_waddr] <= rf_wdata;
        end
    end

    always_comb begin
        alu_wide = '0;
        case (alu_opcode)
            OP_ADD: alu_wide = {1'b0, alu_src1} + {1'b0, alu_src2};
            OP_SUB: alu_wide = {1'b0, alu_src1} - {1'b0, alu_src2};
            OP_DIV: alu_wide = (alu_src2 == 0) ? '0 : {1'b0, alu_src1 / alu_src2};
            OP_AND: alu_wide = {1'b0, alu_src1 & alu_src2};
            default: alu_wide = '0;
        endcase
        alu_result = alu_wide[DATA_W-1:0];
    end

    always @(posedge clk) begin
        if (alu_out_en) flags <= {alu_result == 0, alu_wide[DATA_W]};
    end

    always @(negedge clk) begin
        if (alu_out_en) n_alu_en++;
        if (rf_we)      n_we++;
        if (done)       n_done++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic ui, input logic [15:0] imm,
                         output int lat, output logic e, output logic [2:0] wa,
                         output logic [15:0] wd);
        int w;
        lat = 0; e = 1'bx; wa = 'x; wd = 'x;
        @(negedge clk);
        req_valid = 1'b1; req_opcode = op; req_ar = 1'b0; req_rd = rd;
        req_rs1 = rs1; req_rs2 = rs2; req_use_imm = ui; req_imm = imm;
        w = 0;
        while (!req_ready && w < 8) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 8);
        e = err; wa = rf_waddr; wd = rf_wdata;
        @(negedge clk);
    endtask

    int lat, a0, a1, k, c, we0, en0, dn0;
    logic e;
    logic [2:0] wa;
    logic [15:0] wd;
    logic [1:0] fl0;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_opcode = '0; req_ar = 1'b0; req_rd = '0;
        req_rs1 = '0; req_rs2 = '0; req_use_imm = 1'b0; req_imm = '0; flags = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_we", rf_we, 0);
        chk("rst_alu_en", alu_out_en, 0);
        chk("rst_count", op_count, 0);
        chk("rst_outs", {rf_raddr1, rf_waddr, rf_wdata, alu_src1, alu_opcode}, 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: ADD r3 <= 5 + 7
        en0 = n_alu_en; we0 = n_we;
        do_op(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 16'd0, lat, e, wa, wd);
        chk("add_latency", lat, 3);
        chk("add_err", e, 0);
        chk("add_waddr", wa, 3);
        chk("add_wdata", wd, 16'd12);
        chk("add_alu_en", n_alu_en - en0, 1);
        chk("add_we", n_we - we0, 1);
        chk("add_count", op_count, 1);
        chk("add_reg", regs[3], 16'd12);

        // 2: DIV r1 / imm 0
        en0 = n_alu_en; we0 = n_we; fl0 = flags;
        do_op(OP_DIV, 3'd4, 3'd1, 3'd2, 1'b1, 16'd0, lat, e, wa, wd);
        chk("div0_latency", lat, 3);
        chk("div0_err", e, 1);
        chk("div0_alu_en", n_alu_en - en0, 0);
        chk("div0_we", n_we - we0, 0);
        chk("div0_flags", flags, fl0);
        chk("div0_count", op_count, 1);

        // 3: illegal opcode
        en0 = n_alu_en; we0 = n_we;
        do_op(4'b1111, 3'd5, 3'd1, 3'd2, 1'b0, 16'd0, lat, e, wa, wd);
        chk("ill_err", e, 1);
        chk("ill_alu_en", n_alu_en - en0, 0);
        chk("ill_we", n_we - we0, 0);
        chk("ill_reg", regs[5], 16'd5);

        // 4: back-to-back with req_valid held: SUB r6 <= 3-5, then ADD r7 <= 5+7
        we0 = n_we; k = 0; a0 = -1; a1 = -1;
        @(negedge clk);
        for (int cyc = 0; cyc < 14; cyc++) begin
            if (req_ready) begin
                if (k == 0) begin
                    req_valid = 1'b1; req_opcode = OP_SUB; req_rd = 3'd6;
                    req_rs1 = 3'd4; req_rs2 = 3'd5; req_use_imm = 1'b0;
                    a0 = cyc; k++;
                end else if (k == 1) begin
                    req_opcode = OP_ADD; req_rd = 3'd7; req_rs1 = 3'd1; req_rs2 = 3'd2;
                    a1 = cyc; k++;
                end else begin
                    req_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("b2b_spacing", a1 - a0, 4);
        chk("b2b_sub", regs[6], 16'hFFFE);
        chk("b2b_add", regs[7], 16'd12);
        chk("b2b_we", n_we - we0, 2);
        chk("b2b_count", op_count, 3);

        // 5: reset during EXEC of ADD
        we0 = n_we; dn0 = n_done;
        @(negedge clk);
        req_valid = 1'b1; req_opcode = OP_ADD; req_rd = 3'd0; req_rs1 = 3'd1;
        req_rs2 = 3'd2; req_use_imm = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst5_in_exec", alu_opcode, OP_ADD);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst5_ready", req_ready, 1);
        chk("rst5_count", op_count, 0);
        repeat (4) @(negedge clk);
        chk("rst5_we", n_we - we0, 0);
        chk("rst5_done", n_done - dn0, 0);

        // 6: counter wrap at 2**CNT_W
        c = 0;
        for (int i = 0; i < 15; i++) begin
            do_op(OP_ADD, 3'd0, 3'd1, 3'd2, 1'b0, 16'd0, lat, e, wa, wd);
        end
        chk("wrap_max", op_count, 15);
        do_op(OP_ADD, 3'd0, 3'd1, 3'd2, 1'b0, 16'd0, lat, e, wa, wd);
        chk("wrap_zero", op_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
